// File: rtl/riscv_v_stage_credit_rx.sv
// ============================================================================
// Module      : riscv_v_stage_credit_rx
// Description : Credit-managed receive FIFO at the tail of a fixed-latency
//               vector stage delay line. Optional same-cycle bypass is
//               enabled by defining RISCV_V_CREDIT_RX_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_v_stage_credit_rx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              pipe_valid,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  credits,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow_err
);

    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_credits;
    logic [CNT_W-1:0]   r_occupancy;
    logic               r_overflow_err;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_take;
    logic w_pop;
    logic w_pop_mem;
    logic w_push;
    logic w_drop;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    assign w_full  = (r_occupancy == c_DEPTH);
    assign w_empty = (r_occupancy == '0);

`ifdef RISCV_V_CREDIT_RX_BYPASS_EN
    // Empty FIFO with a ready consumer: hand the arriving item straight through.
    assign w_bypass  = w_empty & pipe_valid & out_ready & ~flush;
    assign out_valid = ~w_empty | w_bypass;
    assign out_data  = ~w_empty ? r_mem[r_rd_ptr] : (w_bypass ? pipe_data : '0);
`else
    assign w_bypass  = 1'b0;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
`endif

    assign issue_ready  = (r_credits != '0);
    assign credits      = r_credits;
    assign occupancy    = r_occupancy;
    assign overflow_err = r_overflow_err;

    // Handshakes are masked during flush so that cycle's inputs have no effect.
    assign w_take    = issue_valid & issue_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign w_pop_mem = w_pop & ~w_bypass;
    assign w_push    = pipe_valid & ~flush & ~w_bypass & (~w_full | w_pop);
    assign w_drop    = pipe_valid & ~flush & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pipe_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_credits      <= c_DEPTH;
            r_occupancy    <= '0;
            r_overflow_err <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_credits   <= c_DEPTH;
            r_occupancy <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop_mem) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_take, w_pop})
                2'b10:   r_credits <= r_credits - CNT_W'(1);
                2'b01:   r_credits <= r_credits + CNT_W'(1);
                default: r_credits <= r_credits;
            endcase
            case ({w_push, w_pop_mem})
                2'b10:   r_occupancy <= r_occupancy + CNT_W'(1);
                2'b01:   r_occupancy <= r_occupancy - CNT_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_v_stage_credit_rx.sv
// ============================================================================
// Module      : tb_riscv_v_stage_credit_rx
// Description : Self-checking bench for riscv_v_stage_credit_rx with a
//               queue-based reference model and a behavioural delay line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_v_stage_credit_rx;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  credits;
    logic [CNT_W-1:0]  occupancy;
    logic              overflow_err;

    riscv_v_stage_credit_rx #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pipe_valid  (pipe_valid),
        .pipe_data   (pipe_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .credits     (credits),
        .occupancy   (occupancy),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, credits as an integer,
    // and the upstream delay line as a simple shift array.
    logic [DATA_W-1:0] m_q[$];
    int                m_credits;
    bit                m_ovf;
    bit                coherent;
    bit                dl_v [LAT];
    logic [DATA_W-1:0] dl_d [LAT];
    logic [DATA_W-1:0] next_data;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int inflight();
        int n = 0;
        for (int i = 0; i < LAT; i++) n += dl_v[i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_credits = DEPTH;
        for (int i = 0; i < LAT; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end
        coherent = 1'b1;
    endtask

    task automatic do_reset();
        #1;
        rst         = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        pipe_valid  = 1'b0;
        pipe_data   = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        m_ovf = 1'b0;
    endtask

    // One clock: drive, check combinational view against the model, advance model.
    task automatic step(input logic iv, input logic ordy, input logic fl,
                        input logic fpv, input logic [DATA_W-1:0] fpd);
        logic              pv;
        logic [DATA_W-1:0] pd;
        logic              take;
        logic              pop;
        logic              byp;
        int                occ;
        #1;
        rst = 1'b0;
        pv  = fpv ? 1'b1 : dl_v[LAT-1];
        pd  = fpv ? fpd : dl_d[LAT-1];
        if (fpv) coherent = 1'b0;
        issue_valid = iv;
        out_ready   = ordy;
        flush       = fl;
        pipe_valid  = pv;
        pipe_data   = pd;
        #1;
        occ = m_q.size();
        byp = 1'b0;
`ifdef RISCV_V_CREDIT_RX_BYPASS_EN
        byp = (occ == 0) && pv && ordy && !fl;
`endif
        check("issue_ready", issue_ready, m_credits != 0);
        check("out_valid", out_valid, (occ != 0) || byp);
        check("out_data", out_data, (occ != 0) ? m_q[0] : (byp ? pd : '0));
        check("credits", credits, m_credits);
        check("occupancy", occupancy, occ);
        check("overflow_err", overflow_err, m_ovf);
        if (coherent) check("invariant", credits + occupancy + inflight(), DEPTH);

        take = iv && (m_credits != 0) && !fl;
        pop  = ((occ != 0) || byp) && ordy && !fl;
        if (fl) begin
            model_clear();
        end else begin
            if (pop && !byp) void'(m_q.pop_front());
            if (pv && !byp) begin
                if (occ < DEPTH || pop) m_q.push_back(pd);
                else                    m_ovf = 1'b1;
            end
            m_credits = m_credits - (take ? 1 : 0) + (pop ? 1 : 0);
            for (int i = LAT - 1; i > 0; i--) begin
                dl_v[i] = dl_v[i-1];
                dl_d[i] = dl_d[i-1];
            end
            dl_v[0] = take;
            dl_d[0] = next_data;
            if (take) next_data = next_data + 1;
        end
        @(posedge clk);
    endtask

    initial begin
        int  issued;
        int  cyc;
        bit  done;
        rst         = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        pipe_valid  = 1'b0;
        pipe_data   = '0;
        out_ready   = 1'b0;
        next_data   = '0;
        m_ovf       = 1'b0;
        model_clear();

        // Reset state
        do_reset();
        step(0, 0, 0, 0, '0);

        // Fill: four back-to-back issues, consumer stalled
        next_data = 32'hA0;
        repeat (4) step(1, 0, 0, 0, '0);
        repeat (LAT) step(0, 0, 0, 0, '0);
        #1;
        check("fill_occ", occupancy, DEPTH);
        check("fill_head", out_data, 32'hA0);
        check("fill_ready", issue_ready, 1'b0);

        // Issue at zero credits with a pop, then issue+pop together
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        #1;
        check("simul_credits", credits, 1);

        // Drain and wrap: ten items streamed at the credit limit
        next_data = 32'hB0;
        issued    = 0;
        done      = 1'b0;
        for (cyc = 0; cyc < 200 && !done; cyc++) begin
            if (issued < 10 && m_credits != 0) issued++;
            step(issued <= 10 && m_credits != 0 && issued > 0 && next_data < 32'hBA, 1, 0, 0, '0);
            done = (next_data == 32'hBA) && (inflight() == 0) && (m_q.size() == 0);
        end
        check("drain_done", done, 1'b1);
        #1;
        check("drain_credits", credits, DEPTH);

        // Overflow: five deliveries with no issues and no pops
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'hC0 + i);
        #1;
        check("ovf_occ", occupancy, DEPTH);
        check("ovf_flag", overflow_err, 1'b1);
        step(0, 0, 1, 0, '0);
        #1;
        check("ovf_after_flush", overflow_err, 1'b1);
        do_reset();
        step(0, 0, 0, 0, '0);

        // Flush with two stored, one credit left and an item arriving
        next_data = 32'hD0;
        repeat (3) step(1, 0, 0, 0, '0);
        repeat (LAT - 1) step(0, 0, 0, 0, '0);
        #1;
        check("preflush_occ", occupancy, 2);
        check("preflush_credits", credits, 1);
        check("preflush_pipe", dl_v[LAT-1], 1'b1);
        step(0, 1, 1, 0, '0);
        #1;
        check("flush_occ", occupancy, 0);
        check("flush_credits", credits, DEPTH);
        check("flush_valid", out_valid, 1'b0);

        // Randomized traffic
        next_data = $urandom;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, 0, '0);
        end

        // Reset in the middle of traffic discards everything
        repeat (3) step(1, 0, 0, 0, '0);
        do_reset();
        step(0, 1, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
